// File: rtl/mem_burst_responder.sv
// Memory-side burst responder: streams one 4-word line per request, critical word
// first, between the cache burst port and a 1-cycle-latency word-wide RAM port.
module mem_burst_responder #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_address,
    input  logic        mem_req,
    input  logic        mem_wren,
    input  logic [15:0] to_mem,
    output logic [15:0] from_mem,
    output logic [1:0]  mem_offset,
    output logic        mem_ready,
    output logic [31:0] ram_address,
    output logic        ram_ren,
    output logic        ram_wren,
    output logic [15:0] ram_wdata,
    input  logic [15:0] ram_rdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_PRIME,
        S_XFER
    } state_t;

    state_t      r_state;
    logic [31:0] r_base;
    logic        r_wren;
    logic [3:0]  r_cnt;
    logic [1:0]  r_k;
    logic [1:0]  r_offset;
    logic        r_ready;
    logic [31:0] r_ram_address;
    logic        r_ram_ren;
    logic        r_ram_wren;

    logic [1:0]  w_k_p1;
    logic [1:0]  w_k_p2;

    assign w_k_p1 = r_k + 2'd1;
    assign w_k_p2 = r_k + 2'd2;

    // All strobes are computed one cycle ahead so every output leaves a flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_base        <= 32'h0;
            r_wren        <= 1'b0;
            r_cnt         <= 4'd0;
            r_k           <= 2'd0;
            r_offset      <= 2'd0;
            r_ready       <= 1'b0;
            r_ram_address <= 32'h0;
            r_ram_ren     <= 1'b0;
            r_ram_wren    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (mem_req) begin
                        r_base <= mem_address;
                        r_wren <= mem_wren;
                        r_k    <= 2'd0;
                        if (WAIT_CYCLES == 0) begin
                            r_state       <= S_PRIME;
                            r_ram_ren     <= ~mem_wren;
                            r_ram_address <= mem_address;
                        end else begin
                            r_state <= S_WAIT;
                            r_cnt   <= WAIT_CYCLES[3:0];
                        end
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt <= 4'd1) begin
                        r_state       <= S_PRIME;
                        r_ram_ren     <= ~r_wren;
                        r_ram_address <= r_base;
                    end
                end
                S_PRIME: begin
                    r_state <= S_XFER;
                    r_k     <= 2'd0;
                    r_ready <= 1'b1;
                    if (r_wren) begin
                        r_offset      <= 2'd1;
                        r_ram_ren     <= 1'b0;
                        r_ram_wren    <= 1'b1;
                        r_ram_address <= r_base;
                    end else begin
                        r_offset      <= 2'd0;
                        r_ram_ren     <= 1'b1;
                        r_ram_address <= {r_base[31:2], r_base[1:0] ^ 2'd1};
                    end
                end
                S_XFER: begin
                    if (r_k == 2'd3) begin
                        r_state    <= S_IDLE;
                        r_k        <= 2'd0;
                        r_offset   <= 2'd0;
                        r_ready    <= 1'b0;
                        r_ram_ren  <= 1'b0;
                        r_ram_wren <= 1'b0;
                    end else begin
                        r_k <= w_k_p1;
                        // Writes: offset runs one word ahead of the address being written.
                        if (r_wren) begin
                            r_offset      <= w_k_p2;
                            r_ram_wren    <= 1'b1;
                            r_ram_address <= {r_base[31:2], r_base[1:0] ^ w_k_p1};
                        end else begin
                            r_offset      <= w_k_p1;
                            r_ram_ren     <= (w_k_p1 != 2'd3);
                            r_ram_address <= {r_base[31:2], r_base[1:0] ^ w_k_p2};
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign mem_offset  = r_offset;
    assign mem_ready   = r_ready;
    assign ram_address = r_ram_address;
    assign ram_ren     = r_ram_ren;
    assign ram_wren    = r_ram_wren;
    assign ram_wdata   = to_mem;
    assign from_mem    = r_ready ? ram_rdata : 16'h0000;

endmodule
